imem_loader: RTL and testbench

Boot-time program loader for the RISC-V core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian instruction words, and writes them sequentially into imem from word address 0. It holds the core in reset until the image is complete. It replaces simulation-only memory preloading with a synthesizable path, parametrised in imem depth and word width.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader_byte_assembler.sv | 64 ++++++
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time imem loader.
package riscv_loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CHK,
        RUN,
        ERR
    } state_e;

    localparam int unsigned HDR_BYTES = 4;
    localparam int unsigned HDR_W     = 8 * HDR_BYTES;
    localparam int unsigned CSUM_W    = 8;

    // True when a header word count does not fit in a 2**addr_w word imem.
    function automatic logic hdr_overflow(input logic [HDR_W-1:0] n, input int unsigned addr_w);
        logic [63:0] lim;
        lim = 64'd1 << addr_w;
        return {32'd0, n} > lim;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader, plus core release flags.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 32
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    // Loader side.
    modport master (
        input  s_valid, s_data,
        output s_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error
    );

    // Stream source / imem / core side.
    modport slave (
        output s_valid, s_data,
        input  s_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error
    );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian word assembler: bytes shift in LSB-first, word_c_o is the
// word as it would read with byte_i as its top byte.
module byte_assembler #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en_i,
    input  logic [7:0]        byte_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] word_c_o,
    output logic              complete_c_o
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign complete_c_o = shift_en_i && (cnt_q == CNT_W'(BYTES - 1));

    // Byte position within the current word.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || complete_c_o) begin
            cnt_d = '0;
        end else if (shift_en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Byte counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    generate
        if (BYTES > 1) begin : g_multi
            logic [DATA_W-9:0] part_q, part_d;

            assign word_c_o = {byte_i, part_q};

            // Holds the bytes received so far, already shifted toward the LSB.
            always_comb begin
                part_d = part_q;
                if (clear_i || complete_c_o) begin
                    part_d = '0;
                end else if (shift_en_i) begin
                    part_d = word_c_o[DATA_W-1:8];
                end
            end

            // Partial-word register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) part_q <= '0;
                else     part_q <= part_d;
            end
        end else begin : g_single
            assign word_c_o = byte_i;
        end
    endgenerate

endmodule

// File: rtl/imem_loader.sv
// Boot-time imem loader: header word count, little-endian payload words
// written from address 0, core held in reset until the image completes.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module imem_loader
    import riscv_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus
);

    localparam int unsigned HDR_CNT_W = $clog2(HDR_BYTES);

`ifdef LOADER_CHECKSUM_EN
    localparam state_e PAYLOAD_END = CHK;
`else
    localparam state_e PAYLOAD_END = RUN;
`endif

    state_e               state_q, state_d;
    logic [HDR_CNT_W-1:0] hdr_cnt_q, hdr_cnt_d;
    logic [HDR_W-1:0]     hdr_q, hdr_d;
    logic [HDR_W-1:0]     word_cnt_q, word_cnt_d;
`ifdef LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0]    csum_q, csum_d;
`endif

    logic                 s_ready_q, s_ready_d;
    logic                 imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]    imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]    imem_wdata_q, imem_wdata_d;
    logic                 cpu_rst_q, cpu_rst_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic                 accept_c;
    logic                 asm_shift_c;
    logic                 asm_clear_c;
    logic                 asm_complete_c;
    logic [DATA_W-1:0]    asm_word_c;

    assign accept_c    = bus.s_valid && s_ready_q;
    assign asm_shift_c = accept_c && (state_q == DATA);

    byte_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk          (clk),
        .rst          (rst),
        .shift_en_i   (asm_shift_c),
        .byte_i       (bus.s_data),
        .clear_i      (asm_clear_c),
        .word_c_o     (asm_word_c),
        .complete_c_o (asm_complete_c)
    );

    // Next-state, counters, checksum and output register inputs.
    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        hdr_d        = hdr_q;
        word_cnt_d   = word_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        asm_clear_c  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        case (state_q)
            HDR: begin
                if (accept_c) begin
                    hdr_d     = {bus.s_data, hdr_q[HDR_W-1:8]};
                    hdr_cnt_d = hdr_cnt_q + HDR_CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ bus.s_data;
`endif
                    if (hdr_cnt_q == HDR_CNT_W'(HDR_BYTES - 1)) begin
                        if (hdr_overflow(hdr_d, ADDR_W)) begin
                            state_d = ERR;
                        end else if (hdr_d == '0) begin
                            state_d = PAYLOAD_END;
                        end else begin
                            state_d     = DATA;
                            word_cnt_d  = '0;
                            asm_clear_c = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (accept_c) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.s_data;
`endif
                    if (asm_complete_c) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ADDR_W'(word_cnt_q);
                        imem_wdata_d = asm_word_c;
                        word_cnt_d   = word_cnt_q + HDR_W'(1);
                        if (word_cnt_q == hdr_q - HDR_W'(1)) begin
                            state_d = PAYLOAD_END;
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept_c) begin
                    state_d = (bus.s_data == csum_q) ? RUN : ERR;
                end
            end
`endif
            default: ;
        endcase

        s_ready_d = (state_d == HDR) || (state_d == DATA) || (state_d == CHK);
        done_d    = (state_q == RUN);
        cpu_rst_d = (state_q != RUN);
        error_d   = (state_q == ERR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HDR;
            hdr_cnt_q    <= '0;
            hdr_q        <= '0;
            word_cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
            s_ready_q    <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            hdr_q        <= hdr_d;
            word_cnt_q   <= word_cnt_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
            s_ready_q    <= s_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word imem (ADDR_W=2, DATA_W=32).
module tb_imem_loader;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;
    localparam int          BYTES  = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    typedef struct {
        logic [31:0]             n;
        logic [3:0][DATA_W-1:0]  w;
        int                      stall_at;
        bit                      bad_csum;
        bit                      exp_err;
    } vec_t;

    wr_t  wr_q[$];
    vec_t vecs[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every imem write mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_t w;
            w.addr = bus.imem_addr;
            w.data = bus.imem_wdata;
            w.cyc  = cyc;
            wr_q.push_back(w);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] n, input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                           input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3,
                           input int stall_at, input bit bad_csum, input bit exp_err);
        vec_t v;
        v.n        = n;
        v.w[0]     = w0;
        v.w[1]     = w1;
        v.w[2]     = w2;
        v.w[3]     = w3;
        v.stall_at = stall_at;
        v.bad_csum = bad_csum;
        v.exp_err  = exp_err;
        vecs.push_back(v);
    endtask

    // Offer one byte; returns 1 ns after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (bus.s_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (bus.s_ready !== 1'b1) begin
            check("s_ready_wait", 64'(bus.s_ready), 64'd1);
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        wr_q.delete();
    endtask

    task automatic send_image(input vec_t v);
        logic [7:0]  b;
        logic [7:0]  csum;
        int          pay;
        int          pre;
        csum = 8'h00;
        pay  = 0;
        for (int i = 0; i < 4; i++) begin
            b = v.n[8*i +: 8];
            send_byte(b);
            csum = csum ^ b;
        end
        if (v.n <= 32'd4) begin
            for (int k = 0; k < int'(v.n); k++) begin
                for (int j = 0; j < BYTES; j++) begin
                    b = v.w[k][8*j +: 8];
                    send_byte(b);
                    csum = csum ^ b;
                    pay++;
                    if (pay == v.stall_at) begin
                        pre = wr_q.size();
                        repeat (5) begin
                            @(posedge clk); #1;
                            check("stall_no_we", 64'(bus.imem_we), 64'd0);
                        end
                        check("stall_wr_count", 64'(wr_q.size()), 64'(pre));
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(v.bad_csum ? 8'h00 : csum);
`endif
        end
    endtask

    // Called right after the final byte of an image has been accepted.
    task automatic check_result(input vec_t v);
        int exp_wr;
        exp_wr = (v.n > 32'd4) ? 0 : int'(v.n);
        check("done_early", 64'(bus.done), 64'd0);
        check("error_early", 64'(bus.error), 64'd0);
        check("cpu_rst_early", 64'(bus.cpu_rst), 64'd1);
        @(posedge clk); #1;
        check("done", 64'(bus.done), 64'(!v.exp_err));
        check("cpu_rst", 64'(bus.cpu_rst), 64'(v.exp_err));
        check("error", 64'(bus.error), 64'(v.exp_err));
        check("s_ready_after", 64'(bus.s_ready), 64'd0);
        check("wr_count", 64'(wr_q.size()), 64'(exp_wr));
        for (int i = 0; i < wr_q.size() && i < exp_wr; i++) begin
            check($sformatf("wr%0d_addr", i), 64'(wr_q[i].addr), 64'(i));
            check($sformatf("wr%0d_data", i), 64'(wr_q[i].data), 64'(v.w[i]));
        end
        if (v.stall_at < 0 && exp_wr >= 2 && wr_q.size() >= 2) begin
            check("b2b_spacing", 64'(wr_q[1].cyc - wr_q[0].cyc), 64'(BYTES));
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;

        add_vec(32'd2, 32'h00000013, 32'h00100093, 32'h0, 32'h0, -1, 1'b0, 1'b0);
        add_vec(32'd2, 32'h00000013, 32'h00100093, 32'h0, 32'h0,  6, 1'b0, 1'b0);
        add_vec(32'd4, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h00000001, -1, 1'b0, 1'b0);
        add_vec(32'd0, 32'h0, 32'h0, 32'h0, 32'h0, -1, 1'b0, 1'b0);
        add_vec(32'd5, 32'h0, 32'h0, 32'h0, 32'h0, -1, 1'b0, 1'b1);
        add_vec(32'h00010002, 32'h0, 32'h0, 32'h0, 32'h0, -1, 1'b0, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        add_vec(32'd2, 32'h00000013, 32'h00100093, 32'h0, 32'h0, -1, 1'b1, 1'b1);
`endif

        // Reset values while rst is held.
        #1;
        check("rst_s_ready", 64'(bus.s_ready), 64'd1);
        check("rst_imem_we", 64'(bus.imem_we), 64'd0);
        check("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        check("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
        check("rst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_error", 64'(bus.error), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            send_image(vecs[i]);
            check_result(vecs[i]);
        end

        // Bytes offered in RUN are ignored.
        do_reset();
        send_image(vecs[0]);
        check_result(vecs[0]);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        check("run_ignore_wr", 64'(wr_q.size()), 64'd2);
        check("run_ignore_done", 64'(bus.done), 64'd1);
        check("run_ignore_ready", 64'(bus.s_ready), 64'd0);

        // Reset after 6 payload bytes, with a byte offered during reset.
        do_reset();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00);
        check("mid_wr_count", 64'(wr_q.size()), 64'd1);
        check("mid_wdata_pre", 64'(bus.imem_wdata), 64'h13);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h10;
        rst         = 1'b1;
        #1;
        check("mid_rst_s_ready", 64'(bus.s_ready), 64'd1);
        check("mid_rst_imem_we", 64'(bus.imem_we), 64'd0);
        check("mid_rst_addr", 64'(bus.imem_addr), 64'd0);
        check("mid_rst_wdata", 64'(bus.imem_wdata), 64'd0);
        check("mid_rst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        wr_q.delete();
        send_image(vecs[0]);
        check_result(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
